// File: rtl/wb_mux_c_seq.sv
// Writeback Bus C mux with a registered output and a memory-wait FSM.
// Optional load sign/zero extension is enabled by defining WBMUX_LOAD_EXT_EN.
module wb_mux_c_seq #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int MEM_TIMEOUT   = 8
) (
  input  logic                     CC_WBMUX_CLOCK_50,
  input  logic                     CC_WBMUX_RESET_InHigh,
  input  logic                     CC_WBMUX_Req_Valid_In,
  input  logic [1:0]               CC_WBMUX_Selector_In,
  input  logic [DATAWIDTH_BUS-1:0] CC_WBMUX_ALU_Data_Bus_In,
  input  logic [DATAWIDTH_BUS-1:0] CC_WBMUX_DataMemory_Data_Bus_In,
  input  logic                     CC_WBMUX_DataMemory_Valid_In,
  input  logic [DATAWIDTH_BUS-1:0] CC_WBMUX_PC_Data_Bus_In,
  input  logic [DATAWIDTH_BUS-1:0] CC_WBMUX_AUX_Data_Bus_In,
  input  logic [1:0]               CC_WBMUX_Size_In,
  input  logic                     CC_WBMUX_Signed_In,
  output logic [DATAWIDTH_BUS-1:0] CC_WBMUX_DataBUS_Out,
  output logic                     CC_WBMUX_Valid_Out,
  output logic                     CC_WBMUX_Busy_Out,
  output logic                     CC_WBMUX_Timeout_Out
);

  localparam int W = DATAWIDTH_BUS;
  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       load;
  logic       tmo;
  logic [W-1:0] mem_ext;
  logic [W-1:0] wb_data;

  logic clk;
  logic rst;
  logic req;
  logic memv;
  logic [1:0] sel;

  assign clk  = CC_WBMUX_CLOCK_50;
  assign rst  = CC_WBMUX_RESET_InHigh;
  assign req  = CC_WBMUX_Req_Valid_In;
  assign memv = CC_WBMUX_DataMemory_Valid_In;
  assign sel  = CC_WBMUX_Selector_In;

`ifdef WBMUX_LOAD_EXT_EN
  logic [1:0] size_q;
  logic       sgn_q;
  logic [1:0] size_use;
  logic       sgn_use;

  function automatic logic [W-1:0] ext(
    input logic [W-1:0] d,
    input logic [1:0]   sz,
    input logic         sg
  );
    logic [W-1:0] r;
    unique case (sz)
      2'd0:    r = {{(W-8){sg & d[7]}}, d[7:0]};
      2'd1:    r = {{(W-16){sg & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // The fast path uses the live size; a waiting load uses the latched one.
  assign size_use = (state == IDLE) ? CC_WBMUX_Size_In : size_q;
  assign sgn_use  = (state == IDLE) ? CC_WBMUX_Signed_In : sgn_q;
  assign mem_ext  = ext(CC_WBMUX_DataMemory_Data_Bus_In, size_use, sgn_use);

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q <= 2'd0;
      sgn_q  <= 1'b0;
    end else if (state == IDLE && req && sel == 2'd1 && !memv) begin
      size_q <= CC_WBMUX_Size_In;
      sgn_q  <= CC_WBMUX_Signed_In;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{CC_WBMUX_Size_In, CC_WBMUX_Signed_In};
  assign mem_ext    = CC_WBMUX_DataMemory_Data_Bus_In;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (sel != 2'd1 || memv) begin
            load = 1'b1;
          end else begin
            state_nxt = WAIT_MEM;
            cnt_nxt   = 8'd0;
          end
        end
      end
      WAIT_MEM: begin
        if (memv) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    CC_WBMUX_Busy_Out = (state == WAIT_MEM);
    wb_data           = mem_ext;
    if (state == IDLE) begin
      unique case (sel)
        2'd0: wb_data = CC_WBMUX_ALU_Data_Bus_In;
        2'd1: wb_data = mem_ext;
        2'd2: wb_data = CC_WBMUX_PC_Data_Bus_In;
        2'd3: wb_data = CC_WBMUX_AUX_Data_Bus_In;
        default: wb_data = mem_ext;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      CC_WBMUX_DataBUS_Out <= '0;
      CC_WBMUX_Valid_Out   <= 1'b0;
      CC_WBMUX_Timeout_Out <= 1'b0;
    end else begin
      CC_WBMUX_Valid_Out   <= load | tmo;
      CC_WBMUX_Timeout_Out <= tmo;
      if (load) begin
        CC_WBMUX_DataBUS_Out <= wb_data;
      end else if (tmo) begin
        CC_WBMUX_DataBUS_Out <= '0;
      end
    end
  end

endmodule

// File: doc/wb_mux_c_seq.md
WB_MUX_C_SEQ -- requirements
Module: wb_mux_c_seq

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32: width of every data port and of the Bus C output.
REQ-002 Parameter MEM_TIMEOUT, default 8: maximum number of WAIT_MEM cycles before abort; legal range 1..255.
REQ-003 CC_WBMUX_CLOCK_50  in  1  single clock; all state updates on its rising edge.
REQ-004 CC_WBMUX_RESET_InHigh  in  1  reset, synchronous and active-high.
REQ-005 CC_WBMUX_Req_Valid_In  in  1  writeback request strobe.
REQ-006 CC_WBMUX_Selector_In  in  2  source select: 0 ALU, 1 data memory, 2 PC, 3 AUX.
REQ-007 CC_WBMUX_ALU_Data_Bus_In  in  DATAWIDTH_BUS  ALU result.
REQ-008 CC_WBMUX_DataMemory_Data_Bus_In  in  DATAWIDTH_BUS  data memory read data.
REQ-009 CC_WBMUX_DataMemory_Valid_In  in  1  memory read data valid.
REQ-010 CC_WBMUX_PC_Data_Bus_In  in  DATAWIDTH_BUS  current PC, for call-linkage writeback.
REQ-011 CC_WBMUX_AUX_Data_Bus_In  in  DATAWIDTH_BUS  auxiliary source (immediate/special register).
REQ-012 CC_WBMUX_Size_In  in  2  load size: 0 byte, 1 half, 2/3 word.
REQ-013 CC_WBMUX_Signed_In  in  1  load sign-extend request.
REQ-014 CC_WBMUX_DataBUS_Out  out  DATAWIDTH_BUS  registered Bus C data.
REQ-015 CC_WBMUX_Valid_Out  out  1  one-cycle pulse, DataBUS_Out holds a new result.
REQ-016 CC_WBMUX_Busy_Out  out  1  high while in WAIT_MEM; requests ignored.
REQ-017 CC_WBMUX_Timeout_Out  out  1  one-cycle pulse on memory-wait abort.

Function
REQ-018 States SHALL be IDLE and WAIT_MEM; Busy_Out SHALL equal (state == WAIT_MEM).
REQ-019 IDLE, Req_Valid_In=1, Selector in {0,2,3}: next edge loads selected source into DataBUS_Out, Valid_Out=1 for one cycle, stays IDLE (latency 1).
REQ-020 IDLE, Req_Valid_In=1, Selector=1, DataMemory_Valid_In=1 same cycle: next edge loads (extended) memory data, Valid_Out=1, stays IDLE.
REQ-021 IDLE, Req_Valid_In=1, Selector=1, DataMemory_Valid_In=0: next edge -> WAIT_MEM, Size_In/Signed_In latched, wait counter cleared to 0.
REQ-022 WAIT_MEM, DataMemory_Valid_In=1: next edge loads memory data extended per latched Size/Signed, Valid_Out=1, -> IDLE.
REQ-023 WAIT_MEM, DataMemory_Valid_In=0: counter increments; when counter = MEM_TIMEOUT-1, next edge sets DataBUS_Out=0, Valid_Out=1, Timeout_Out=1, -> IDLE.
REQ-024 Memory valid and timeout in same cycle: data SHALL win; Timeout_Out stays 0.
REQ-025 Req_Valid_In in WAIT_MEM SHALL be ignored; DataMemory_Valid_In in IDLE without a Selector=1 request SHALL be ignored.
REQ-026 DataBUS_Out SHALL hold its last value whenever Valid_Out=0.
REQ-027 Back-to-back non-memory requests SHALL each produce a Valid_Out pulse on consecutive cycles.

Reset
REQ-028 Reset=1 at an edge: state IDLE, counter 0, DataBUS_Out=0, Valid_Out=0, Busy_Out=0, Timeout_Out=0; reset has priority over all inputs.
REQ-029 Reset during WAIT_MEM SHALL abort the load with no Valid_Out or Timeout_Out pulse.

Configuration
REQ-030 Macro WBMUX_LOAD_EXT_EN defined: byte loads use bits [7:0], half loads bits [15:0], zero- or sign-extended per Signed; word loads pass unchanged.
REQ-031 WBMUX_LOAD_EXT_EN undefined: memory data SHALL pass unchanged; Size_In/Signed_In unused; all timing identical.

Verification
REQ-032 Req=1, Sel=0, ALU=0x1234_5678 -> next cycle DataBUS_Out=0x1234_5678, Valid_Out=1 one cycle, Busy_Out=0.
REQ-033 Req=1, Sel=1, MemValid=0; MemValid=1 two cycles later with 0xCAFE_0080 -> Busy 2 cycles, then DataBUS_Out=0xCAFE_0080, Valid pulse.
REQ-034 With WBMUX_LOAD_EXT_EN: Sel=1, Size=0, Signed=1, mem=0x0000_0080 -> 0xFFFF_FF80; Signed=0 -> 0x0000_0080.
REQ-035 MEM_TIMEOUT=8, Sel=1, MemValid held 0 -> after 8 WAIT_MEM cycles DataBUS_Out=0, Valid_Out=1, Timeout_Out=1, Busy_Out=0.
REQ-036 Reset=1 in 3rd WAIT_MEM cycle, MemValid=1 next cycle -> all outputs 0, no Valid pulse, state IDLE.
REQ-037 Sel=2 PC=0x40 then Sel=3 AUX=0x7 consecutive -> Valid pulses two cycles, outputs 0x40 then 0x7.
